ext_load_sequencer: RTL

- Host-side load stage directly upstream of the point-cloud accelerator top level.
- Accepts a command stream plus two data streams: global-buffer lines and neighbor-index-table (NIT) rows.
- Converts them into the top level's external write signals (GB_data_line, waddr_external, global_buf_write_external, NIT_addr_external, NIT_external_data).
- Sequences the `start` and `LOAD_DONE` pulses that run a layer.

---
 rtl/ext_load_sequencer.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/ext_load_sequencer.sv
// ============================================================================
// Module      : ext_load_sequencer
// Description : Host-side load stage that turns a command stream plus GB-line
//               and NIT-row streams into external write strobes for the
//               point-cloud accelerator, and sequences its start/LOAD_DONE
//               pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ext_load_sequencer #(
    parameter int GB_ADDR_WIDTH  = 17,
    parameter int GB_DATA_WIDTH  = 128,
    parameter int NIT_ADDR_WIDTH = 12,
    parameter int NIT_DATA_WIDTH = 330,
    parameter int LEN_WIDTH      = 13
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [1:0]                cmd_type,
    input  logic [GB_ADDR_WIDTH-1:0]  cmd_addr,
    input  logic [LEN_WIDTH-1:0]      cmd_len,

    input  logic                      gb_valid,
    output logic                      gb_ready,
    input  logic [GB_DATA_WIDTH-1:0]  gb_data,

    input  logic                      nit_valid,
    output logic                      nit_ready,
    input  logic [NIT_DATA_WIDTH-1:0] nit_data,

    output logic                      global_buf_write_external,
    output logic [GB_ADDR_WIDTH-1:0]  waddr_external,
    output logic [GB_DATA_WIDTH-1:0]  GB_data_line,

    output logic                      nit_write,
    output logic [NIT_ADDR_WIDTH-1:0] NIT_addr_external,
    output logic [NIT_DATA_WIDTH-1:0] NIT_external_data,

    output logic                      LOAD_DONE,
    output logic                      start,
    output logic                      busy,
    output logic [LEN_WIDTH-1:0]      beats_left
);

    localparam logic [1:0] c_cmd_gb    = 2'd0;
    localparam logic [1:0] c_cmd_nit   = 2'd1;
    localparam logic [1:0] c_cmd_done  = 2'd2;
    localparam logic [1:0] c_cmd_start = 2'd3;

    localparam logic [GB_ADDR_WIDTH-1:0] c_ptr_one  = GB_ADDR_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]     c_len_one  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]     c_len_zero = '0;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_GB_LOAD  = 2'd1,
        S_NIT_LOAD = 2'd2,
        S_PULSE    = 2'd3
    } state_t;

    state_t                     r_state;
    logic [GB_ADDR_WIDTH-1:0]   r_ptr;

    logic w_cmd_fire;
    logic w_gb_fire;
    logic w_nit_fire;
    logic w_last_beat;

    // Handshake readies are pure decodes of the state register.
    assign cmd_ready = (r_state == S_IDLE);
    assign gb_ready  = (r_state == S_GB_LOAD);
    assign nit_ready = (r_state == S_NIT_LOAD);
    assign busy      = (r_state != S_IDLE);

    assign w_cmd_fire  = cmd_valid & cmd_ready;
    assign w_gb_fire   = gb_valid  & gb_ready;
    assign w_nit_fire  = nit_valid & nit_ready;
    assign w_last_beat = (beats_left == c_len_one);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state                   <= S_IDLE;
            r_ptr                     <= '0;
            beats_left                <= '0;
            global_buf_write_external <= 1'b0;
            waddr_external            <= '0;
            GB_data_line              <= '0;
            nit_write                 <= 1'b0;
            NIT_addr_external         <= '0;
            NIT_external_data         <= '0;
            LOAD_DONE                 <= 1'b0;
            start                     <= 1'b0;
        end else begin
            // Strobes and pulses are single-cycle; address/data hold.
            global_buf_write_external <= 1'b0;
            nit_write                 <= 1'b0;
            LOAD_DONE                 <= 1'b0;
            start                     <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (w_cmd_fire) begin
                        r_ptr      <= cmd_addr;
                        beats_left <= cmd_len;
                        case (cmd_type)
                            c_cmd_gb: begin
                                if (cmd_len != c_len_zero) begin
                                    r_state <= S_GB_LOAD;
                                end
                            end
                            c_cmd_nit: begin
                                if (cmd_len != c_len_zero) begin
                                    r_state <= S_NIT_LOAD;
                                end
                            end
                            c_cmd_done: begin
                                LOAD_DONE <= 1'b1;
                                r_state   <= S_PULSE;
                            end
                            c_cmd_start: begin
                                start   <= 1'b1;
                                r_state <= S_PULSE;
                            end
                            default: r_state <= S_IDLE;
                        endcase
                    end
                end

                S_GB_LOAD: begin
                    if (w_gb_fire) begin
                        global_buf_write_external <= 1'b1;
                        waddr_external            <= r_ptr;
                        GB_data_line              <= gb_data;
                        r_ptr                     <= r_ptr + c_ptr_one;
                        beats_left                <= beats_left - c_len_one;
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_NIT_LOAD: begin
                    // Low bits of the full-width pointer wrap modulo 2^NIT_ADDR_WIDTH.
                    if (w_nit_fire) begin
                        nit_write         <= 1'b1;
                        NIT_addr_external <= r_ptr[NIT_ADDR_WIDTH-1:0];
                        NIT_external_data <= nit_data;
                        r_ptr             <= r_ptr + c_ptr_one;
                        beats_left        <= beats_left - c_len_one;
                        if (w_last_beat) begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_PULSE: begin
                    r_state <= S_IDLE;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
